// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_pkg;

  // Timer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A preset nibble above 9 is not a legal decimal digit; treat it as 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down-counter: load, or take a borrow and step down.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic [3:0] q_digit,
  output logic       borrow_out
);

  // Digit register: load beats borrow; a borrow into 0 rolls to 9.
  always_ff @(posedge clk) begin
    if (rst)
      q_digit <= 4'd0;
    else if (load)
      q_digit <= bcd_clamp(load_digit);
    else if (borrow_in)
      q_digit <= (q_digit == 4'd0) ? BCD_MAX : q_digit - 4'd1;
  end

  // Ripple the borrow onward only when this digit underflowed.
  assign borrow_out = borrow_in && (q_digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown with load, start/pause and a one-cycle expiry pulse.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  // A BCD value of one has the same bit pattern as binary one.
  localparam logic [4*DIGITS-1:0] Q_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              dec;
  logic              q_is_one;
  logic [DIGITS:0]   borrow;
  logic              chain_unused;

  assign zero     = (q == '0);
  assign q_is_one = (q == Q_ONE);

  // Decrement only on a tick in RUN that is not overridden by load or pause.
  // The !zero guard means the chain can never underflow past the top digit.
  assign dec       = (state_q == RUN) && tick && !load && !pause && !zero;
  assign borrow[0] = dec;

  // The top borrow would signal a wrap to 99..9, which dec gating prevents.
  assign chain_unused = borrow[DIGITS];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_digit (load_val[4*g +: 4]),
        .borrow_in  (borrow[g]),
        .q_digit    (q[4*g +: 4]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state: load > pause > start > tick.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start)
            state_d = zero ? DONE : RUN;
        end
        RUN: begin
          if (pause)
            state_d = PAUSED;
          else if (tick && q_is_one)
            state_d = DONE;
        end
        PAUSED: begin
          if (start)
            state_d = RUN;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags straight off the state register.
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized + directed scoreboard bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] q;
  logic         running, zero, done;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .q        (q),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic         running;
    logic         zero;
    logic         done;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  // Reference model: the count as a plain integer, mode 0 idle / 1 counting /
  // 2 held / 3 expired.
  int m_cnt  = 0;
  int m_mode = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] raw);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(raw[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic cyc(input logic r, input logic l, input logic [W-1:0] lv,
                     input logic s, input logic p, input logic t);
    @(negedge clk);
    rst = r; load = l; load_val = lv; start = s; pause = p; tick = t;
    if (r) begin
      m_cnt = 0; m_mode = 0;
    end else if (l) begin
      m_cnt = clamp_val(lv); m_mode = 0;
    end else begin
      case (m_mode)
        0: if (s) m_mode = (m_cnt == 0) ? 3 : 1;
        1: begin
          if (p) m_mode = 2;
          else if (t) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_mode = 3;
          end
        end
        2: if (s) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
    exp_q.push_back({to_bcd(m_cnt), m_mode == 1, m_cnt == 0, m_mode == 3});
  endtask

  task automatic idle_c();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ld(input logic [W-1:0] v);
    cyc(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic st();
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic tk(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  obs_t mon_e, mon_a;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {q, running, zero, done};
        n_tests++;
        step++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL outputs step %0d: got q=%h running=%b zero=%b done=%b, want q=%h running=%b zero=%b done=%b",
                   step, mon_a.q, mon_a.running, mon_a.zero, mon_a.done,
                   mon_e.q, mon_e.running, mon_e.zero, mon_e.done);
        end
      end
    end
  end

  logic [W-1:0] rv;
  initial begin
    // Reset
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    // Count 12 down to 0
    ld(16'h0012); st(); tk(12); idle_c(); idle_c();
    // Borrow across digits
    ld(16'h1000); st(); tk(2); idle_c();
    // Clamp, then start from zero, ticks while idle do nothing
    ld(16'hF9A3); idle_c();
    ld(16'h0000); st(); idle_c(); tk(2);
    // Pause / resume
    ld(16'h0005); st(); tk(2);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    tk(5);
    st(); tk(3); idle_c();
    // Load + start + tick in RUN
    ld(16'h0050); st(); tk(1);
    cyc(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b1);
    tk(1);
    // Mid-count reset
    st(); tk(1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle_c();
    // Pause with tick, then start with tick while paused
    ld(16'h0020); st(); tk(1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    tk(2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) rv = to_bcd(int'($urandom_range(0, 25)));
      else rv = W'($urandom);
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 4, rv,
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 70);
    end
    idle_c();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
